// File: rtl/rc_tdc_pkg.sv
// -----------------------------------------------------------------------------
// rc_tdc_pkg
// Shared types and default sizing for the RC time-to-digital sequencer.
//   state_t          : sequencer FSM states
//   DEF_CNT_W        : default charge-time counter / result width
//   DEF_DSCH_W       : default discharge-hold configuration width
//   DEF_SYNC_STAGES  : default depth of the comparator synchronizer
// -----------------------------------------------------------------------------
package rc_tdc_pkg;

  localparam int DEF_CNT_W       = 24;
  localparam int DEF_DSCH_W      = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    CHARGE    = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/rc_tdc_sync.sv
// -----------------------------------------------------------------------------
// rc_tdc_sync
// Multi-flop synchronizer for the asynchronous RC comparator output.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset, clears every stage
//   d      in  raw asynchronous input
//   q      out input delayed by SYNC_STAGES clk cycles
// -----------------------------------------------------------------------------
module rc_tdc_sync
  import rc_tdc_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift-and-insert form keeps the description valid for a single stage too.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= (stages << 1) | SYNC_STAGES'(d);
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/rc_tdc_sequencer.sv
// -----------------------------------------------------------------------------
// rc_tdc_sequencer
// Measures the charge time of an external RC network: discharge for a
// configurable hold time, raise step_set, count clk cycles until the
// synchronized comparator trips, repeat 2^cfg_avg_log2 times and report the
// truncated average. A charge that reaches the counter limit aborts the burst
// and reports all-ones with a sticky overflow flag.
// Ports:
//   clk            in  system clock, rising edge
//   rst_n          in  synchronous active-low reset
//   start          in  one-cycle burst request, honoured only in IDLE
//   cfg_avg_log2   in  log2 of samples per burst, latched on start
//   cfg_discharge  in  minimum discharge cycles (0 acts as 1), latched on start
//   step_input     in  raw comparator output, asynchronous
//   step_set       out registered RC excitation, 1 = charge
//   busy           out high whenever the FSM is not IDLE
//   done           out one-cycle pulse while count_out carries a new result
//   count_out      out averaged charge time in clk cycles
//   overflow       out sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module rc_tdc_sequencer
  import rc_tdc_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DSCH_W      = DEF_DSCH_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cfg_avg_log2,
  input  logic [DSCH_W-1:0] cfg_discharge,
  input  logic              step_input,
  output logic              step_set,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count_out,
  output logic              overflow
);

  // Up to eight samples of at most 2^CNT_W-1 each: three extra bits never wrap.
  localparam int ACC_W = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  state_t state, next_state;

  logic              sync_in;
  logic [1:0]        avg_log2;
  logic [DSCH_W-1:0] hold_target;   // max(cfg_discharge,1) - 1
  logic [DSCH_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  charge_cnt;
  logic [ACC_W-1:0]  acc;
  logic [3:0]        sample_idx;

  logic hold_done;
  logic samples_left;
  logic charge_full;

  rc_tdc_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (step_input),
    .q     (sync_in)
  );

  // hold_cnt is 0 in the first DISCHARGE cycle, so the phase lasts at least
  // hold_target+1 cycles.
  assign hold_done    = (hold_cnt >= hold_target);
  assign samples_left = (sample_idx < (4'd1 << avg_log2));
  assign charge_full  = (charge_cnt == CNT_MAX);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so that all
  // flops update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) next_state = DISCHARGE;
      end
      DISCHARGE: begin
        // A comparator still reading high means the cap is not yet empty.
        if (hold_done && !sync_in) begin
          next_state = (samples_left && !overflow) ? CHARGE : DONE;
        end
      end
      CHARGE: begin
        if (sync_in || charge_full) next_state = DISCHARGE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: configuration, counters, accumulator, registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_set    <= 1'b0;
      overflow    <= 1'b0;
      count_out   <= '0;
      avg_log2    <= '0;
      hold_target <= '0;
      hold_cnt    <= '0;
      charge_cnt  <= '0;
      acc         <= '0;
      sample_idx  <= '0;
    end else begin
      // Excitation follows the upcoming state so it is high exactly while
      // charging, except that it drops one cycle early on the full-scale
      // count: a timed-out sample charges for exactly CNT_MAX cycles.
      step_set <= (next_state == CHARGE) &&
                  !((state == CHARGE) && (charge_cnt == CNT_LAST));

      unique case (state)
        IDLE: begin
          if (start) begin
            avg_log2    <= cfg_avg_log2;
            hold_target <= (cfg_discharge == '0) ? '0 : cfg_discharge - 1'b1;
            hold_cnt    <= '0;
            acc         <= '0;
            sample_idx  <= '0;
            overflow    <= 1'b0;
          end
        end
        DISCHARGE: begin
          // Saturate so a stuck comparator cannot wrap the hold count.
          if (!hold_done) hold_cnt <= hold_cnt + 1'b1;
          if (next_state == CHARGE) charge_cnt <= '0;
          if (next_state == DONE) begin
            count_out <= overflow ? CNT_MAX : CNT_W'(acc >> avg_log2);
          end
        end
        CHARGE: begin
          charge_cnt <= charge_cnt + 1'b1;
          if (sync_in) begin
            acc        <= acc + ACC_W'(charge_cnt);
            sample_idx <= sample_idx + 1'b1;
            hold_cnt   <= '0;
          end else if (charge_full) begin
            overflow   <= 1'b1;
            hold_cnt   <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc_tdc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rc_tdc_sequencer
// Self-checking bench for rc_tdc_sequencer (CNT_W=8 so the timeout is short).
// An RC model raises step_input D full step_set-high cycles after step_set
// rises, D taken from d_q per sample. Expected burst results are queued when a
// burst is started and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_rc_tdc_sequencer;

  localparam int CNT_W       = 8;
  localparam int DSCH_W      = 16;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        cfg_avg_log2 = '0;
  logic [DSCH_W-1:0] cfg_discharge = '0;
  logic              step_input = 1'b0;
  logic              step_set;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count_out;
  logic              overflow;

  rc_tdc_sequencer #(
    .CNT_W       (CNT_W),
    .DSCH_W      (DSCH_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_avg_log2  (cfg_avg_log2),
    .cfg_discharge (cfg_discharge),
    .step_input    (step_input),
    .step_set      (step_set),
    .busy          (busy),
    .done          (done),
    .count_out     (count_out),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] count;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   d_q[$];
  bit   rc_stuck = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Statistics gathered by the monitor, reset by start_burst.
  int pulses   = 0;
  int min_low  = 0;
  int last_hi  = 0;
  int done_cnt = 0;

  // ---------------------------------------------------------------------------
  // RC model: after each rising edge, if step_set has already been high for
  // d_q[0] full cycles, the comparator trips. The cap discharges as soon as
  // step_set drops, and the next sample delay becomes current.
  // ---------------------------------------------------------------------------
  initial begin : rc_model
    int hi_cnt;
    bit prev_ss;
    hi_cnt  = 0;
    prev_ss = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (step_set === 1'b1) begin
        if (d_q.size() > 0 && hi_cnt == d_q[0]) step_input = 1'b1;
        hi_cnt++;
      end else begin
        if (prev_ss && d_q.size() > 0) void'(d_q.pop_front());
        hi_cnt     = 0;
        step_input = rc_stuck;
      end
      prev_ss = (step_set === 1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor and scoreboard
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit   prev_ss;
    int   low_run;
    int   hi_run;
    exp_t e;
    prev_ss = 1'b0;
    low_run = 0;
    hi_run  = 0;
    forever begin
      @(negedge clk);
      if (step_set === 1'b1) begin
        if (!prev_ss) begin
          pulses++;
          if (low_run < min_low) min_low = low_run;
          hi_run = 0;
        end
        hi_run++;
        low_run = 0;
      end else begin
        if (prev_ss) last_hi = hi_run;
        low_run = (busy === 1'b1) ? low_run + 1 : 0;
      end
      prev_ss = (step_set === 1'b1);
      if (done === 1'b1) begin
        done_cnt++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: count_out=%0d overflow=%0b with no result pending",
                   count_out, overflow);
        end else begin
          e = sb.pop_front();
          if (count_out !== e.count || overflow !== e.ovf) begin
            n_fail++;
            $display("FAIL burst_result: got count_out=%0d overflow=%0b, expected count_out=%0d overflow=%0b",
                     count_out, overflow, e.count, e.ovf);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Drives a one-cycle start and queues the expected result. Returns 1 time
  // unit after the edge that samples start.
  task automatic start_burst(input logic [1:0] avg, input int dsch,
                             input logic [CNT_W-1:0] exp_cnt, input logic exp_ovf);
    exp_t e;
    @(negedge clk);
    cfg_avg_log2  = avg;
    cfg_discharge = DSCH_W'(dsch);
    start         = 1'b1;
    e.count       = exp_cnt;
    e.ovf         = exp_ovf;
    sb.push_back(e);
    pulses  = 0;
    min_low = 1 << 30;
    last_hi = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts step_set-low cycles from the start edge to the first charge cycle.
  task automatic wait_first_charge(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (step_set === 1'b1) break;
      n++;
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    n_checks++;
    if (i == budget) begin
      n_fail++;
      $display("FAIL %s_done_wait: no done within %0d cycles, expected a done pulse", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int ss_hi;
    int busy_hi;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (step_set !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got step_set=%b busy=%b done=%b overflow=%b, expected all 0",
               step_set, busy, done, overflow);
    end
    n_checks++;
    if (count_out !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got count_out=%0d, expected 0", count_out);
    end
    rst_n   = 1'b1;
    ss_hi   = 0;
    busy_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (step_set !== 1'b0) ss_hi++;
      if (busy !== 1'b0) busy_hi++;
    end
    n_checks++;
    if (ss_hi != 0) begin
      n_fail++;
      $display("FAIL idle_no_step_set: step_set high %0d cycles without start, expected 0", ss_hi);
    end
    n_checks++;
    if (busy_hi != 0) begin
      n_fail++;
      $display("FAIL idle_not_busy: busy high %0d cycles without start, expected 0", busy_hi);
    end
  endtask

  task automatic test_single();
    int n;
    int d0;
    d0 = done_cnt;
    d_q = '{100};
    start_burst(2'd0, 10, 8'd102, 1'b0);
    wait_first_charge(n);
    n_checks++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL single_discharge_len: got %0d low cycles before charge, expected 10", n);
    end
    wait_done("single", 400);
    n_checks++;
    if (pulses != 1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL single_counts: got pulses=%0d dones=%0d, expected pulses=1 dones=1",
               pulses, done_cnt - d0);
    end
  endtask

  task automatic test_averaging();
    d_q = '{100, 101, 102, 103};
    start_burst(2'd2, 10, 8'd103, 1'b0);
    wait_done("averaging", 2000);
    n_checks++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL avg_pulses: got %0d step_set pulses, expected 4", pulses);
    end
    n_checks++;
    if (min_low < 10) begin
      n_fail++;
      $display("FAIL avg_discharge_min: got min %0d low cycles before a pulse, expected >= 10", min_low);
    end
  endtask

  task automatic test_timeout();
    int d0;
    d0 = done_cnt;
    d_q.delete();
    start_burst(2'd2, 10, 8'hFF, 1'b1);
    wait_done("timeout", 2000);
    n_checks++;
    if (last_hi != 255) begin
      n_fail++;
      $display("FAIL timeout_high_len: got step_set high %0d cycles, expected 255", last_hi);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL timeout_abort: got %0d step_set pulses, expected 1", pulses);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL timeout_done_count: got %0d done pulses, expected 1", done_cnt - d0);
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got overflow=%b after burst, expected 1", overflow);
    end
  endtask

  task automatic test_cfg_zero();
    int n;
    d_q = '{5, 7};   // samples 7 and 9, average 8
    start_burst(2'd1, 0, 8'd8, 1'b0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got overflow=%b after start, expected 0", overflow);
    end
    wait_first_charge(n);
    n_checks++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL zero_discharge_len: got %0d discharge cycles, expected 1", n);
    end
    wait_done("cfg_zero", 500);
  endtask

  task automatic test_truncate();
    d_q = '{0, 1, 2, 3, 4, 5, 6, 7};   // samples 2..9 sum 44, 44>>3 = 5
    start_burst(2'd3, 3, 8'd5, 1'b0);
    wait_done("truncate", 2000);
    n_checks++;
    if (pulses != 8) begin
      n_fail++;
      $display("FAIL trunc_pulses: got %0d step_set pulses, expected 8", pulses);
    end
  endtask

  task automatic test_stuck();
    int n;
    int ss_hi;
    int busy_lo;
    // Part A: comparator stuck well past the hold time.
    rc_stuck   = 1'b1;
    step_input = 1'b1;
    repeat (4) @(negedge clk);
    d_q = '{20};
    start_burst(2'd0, 20, 8'd22, 1'b0);
    ss_hi   = 0;
    busy_lo = 0;
    repeat (40) begin
      @(negedge clk);
      if (step_set !== 1'b0) ss_hi++;
      if (busy !== 1'b1) busy_lo++;
    end
    n_checks++;
    if (ss_hi != 0 || busy_lo != 0) begin
      n_fail++;
      $display("FAIL stuck_hold: got step_set high %0d, busy low %0d cycles, expected 0 and 0",
               ss_hi, busy_lo);
    end
    rc_stuck   = 1'b0;
    step_input = 1'b0;
    // Hold is complete: charge starts as soon as the low level is synchronized.
    wait_first_charge(n);
    n_checks++;
    if (n != SYNC_STAGES) begin
      n_fail++;
      $display("FAIL stuck_release: got %0d cycles from release to charge, expected %0d",
               n, SYNC_STAGES);
    end
    wait_done("stuck_a", 500);
    // Part B: released early, the hold count still governs.
    rc_stuck   = 1'b1;
    step_input = 1'b1;
    repeat (4) @(negedge clk);
    d_q = '{30};
    start_burst(2'd0, 20, 8'd32, 1'b0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 5) begin
        rc_stuck   = 1'b0;
        step_input = 1'b0;
      end
      if (step_set === 1'b1) break;
      n++;
    end
    n_checks++;
    if (n != 20) begin
      n_fail++;
      $display("FAIL stuck_early_release: got %0d cycles before charge, expected 20", n);
    end
    wait_done("stuck_b", 500);
  endtask

  task automatic test_back_to_back();
    int n;
    int i;
    int d0;
    // Reset in the middle of a charge.
    d_q = '{100};
    start_burst(2'd0, 10, 8'd102, 1'b0);
    wait_first_charge(n);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || step_set !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset_flags: got busy=%b step_set=%b done=%b overflow=%b, expected all 0",
               busy, step_set, done, overflow);
    end
    n_checks++;
    if (count_out !== '0) begin
      n_fail++;
      $display("FAIL midop_reset_count: got count_out=%0d, expected 0", count_out);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Starts while busy are ignored; a start coincident with done too.
    d0  = done_cnt;
    d_q = '{40};
    start_burst(2'd0, 10, 8'd42, 1'b0);
    repeat (5) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    n_checks++;
    if (i == 500) begin
      n_fail++;
      $display("FAIL b2b_done_wait: no done within 500 cycles, expected a done pulse");
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_on_done: got busy=%b after start during done, expected 0", busy);
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL start_vs_done: got %0d done pulses for 7 starts, expected 1", done_cnt - d0);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_averaging();
    test_timeout();
    test_cfg_zero();
    test_truncate();
    test_stuck();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rc_tdc_sequencer.md
RC_TDC_SEQUENCER -- requirements
Module: rc_tdc_sequencer

Interface
REQ-001 Parameter CNT_W, default 24: width of the charge-time counter and of count_out.
REQ-002 Parameter DSCH_W, default 16: width of the discharge-hold configuration.
REQ-003 Parameter SYNC_STAGES, default 2: flop depth of the step_input synchronizer.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin a measurement burst.
REQ-008 cfg_avg_log2  in  2  samples per burst = 2^cfg_avg_log2 (1, 2, 4 or 8); sampled on accepted start.
REQ-009 cfg_discharge  in  DSCH_W  minimum discharge cycles; sampled on accepted start; 0 is treated as 1.
REQ-010 step_input  in  1  raw RC comparator output, asynchronous to clk.
REQ-011 step_set  out  1  RC excitation: 1 charges the capacitor, 0 discharges it.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 done  out  1  one-cycle pulse when count_out is updated.
REQ-014 count_out  out  CNT_W  averaged charge time in clk cycles; holds its value until the next done.
REQ-015 overflow  out  1  sticky timeout flag; cleared on the next accepted start.

Function
REQ-016 step_input SHALL pass through SYNC_STAGES flops before use ("sync_in"); no other logic samples the raw input.
REQ-017 States SHALL be IDLE, DISCHARGE, CHARGE and DONE.
REQ-018 IDLE, start=1: latch the configuration, clear the accumulator, the sample index and overflow, then enter DISCHARGE; start is ignored outside IDLE.
REQ-019 DISCHARGE: step_set=0; the hold counter counts to max(cfg_discharge,1); exit only when the count is complete and sync_in=0, so a stuck-high sync_in holds the state indefinitely.
REQ-020 DISCHARGE exit: go to CHARGE if the sample index < 2^cfg_avg_log2 and no overflow is pending, else go to DONE.
REQ-021 CHARGE: step_set=1; the charge counter clears on entry and increments by 1 every cycle in CHARGE.
REQ-022 CHARGE, sync_in=1: add the charge-counter value to the accumulator, increment the sample index, enter DISCHARGE.
REQ-023 Sample value SHALL equal D+SYNC_STAGES, where D is the number of step_set-high cycles before raw step_input rises.
REQ-024 CHARGE, counter = 2^CNT_W-1 with sync_in=0: set overflow, abort the remaining samples, enter DISCHARGE; the next exit goes to DONE.
REQ-025 Accumulator width SHALL be CNT_W+3 bits and can never wrap.
REQ-026 DONE, one cycle: done=1; count_out = accumulator >> cfg_avg_log2 (truncating), or all-ones if overflow is set; next state IDLE.
REQ-027 start coincident with done SHALL be ignored (the FSM is in DONE, not IDLE).
REQ-028 step_set SHALL be registered: no combinational path from any input.

Reset
REQ-029 rst_n=0 at any clock edge, in any state including mid-CHARGE: next state IDLE; step_set, busy, done and overflow = 0; count_out, accumulator and all counters = 0.
REQ-030 No output SHALL glitch high during reset; after reset is released, a start is required before step_set can rise.

Structure
REQ-031 Package rc_tdc_pkg SHALL hold the state enum and the default CNT_W/DSCH_W/SYNC_STAGES constants.
REQ-032 The synchronizer SHALL be a sub-module named rc_tdc_sync (parameter SYNC_STAGES, ports clk, rst_n, d, q).
REQ-033 The FSM, counters and accumulator SHALL reside in rc_tdc_sequencer itself.

Verification
REQ-034 Single sample: cfg_avg_log2=0, cfg_discharge=10, RC model rises D=100 cycles after step_set -> done pulse, count_out=102, overflow=0.
REQ-035 Averaging: cfg_avg_log2=2, successive D=100,101,102,103 -> four step_set pulses, each preceded by at least 10 low cycles; count_out=103 (414>>2).
REQ-036 Timeout: CNT_W=8, step_input never rises -> step_set high for 255 cycles, overflow=1, count_out=8'hFF, exactly one done pulse.
REQ-037 Stuck comparator: step_input held 1 at start -> stays in DISCHARGE with step_set=0; release to 0 -> CHARGE begins only after the hold count completes.
REQ-038 Mid-op reset: rst_n=0 for 1 cycle during CHARGE -> next cycle IDLE, step_set=0, busy=0, count_out=0; starts issued while busy=1 are ignored (start count vs done count).
REQ-039 cfg_discharge=0 -> each DISCHARGE phase lasts exactly 1 cycle when sync_in=0.
